tfa_pipelined_addsub: RTL and testbench
=======================================

// Module: tfa_pipelined_addsub
// PURPOSE
//   Parametrised, pipelined add/subtract unit built from transmission-function full-adder cells.
//   The WIDTH-bit operation is split into STAGES equal slices. Each slice is a ripple of TFA cells.
//   A register boundary sits between slices, carrying the slice carry forward.
//   Valid/ready streaming interface at both ends; sits between operand sources and the accumulator datapath.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth = number of slices (1..WIDTH); slice width SW = WIDTH/STAGES
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit can accept operand beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result this cycle
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (sub mode: 1 = no borrow)
//   overflow   out  1      two's-complement overflow: carry into MSB XOR cout
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): all stage valid bits 0, all data/carry regs 0.
//     Outputs: out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 one cycle after reset release.
//   - Transfer occurs on a rising edge where valid&ready are both high, at each end.
//   - Operand capture at stage 0: b_eff = sub ? ~b : b; c_eff = sub ? 1 : cin.
//     Stage 0 registers the result of slice 0, its carry, and the pending upper slices of a/b_eff.
//   - Stage k (1..STAGES-1) computes slice k from the registered carry of stage k-1 and registers it.
//     Lower slices already computed are passed through unchanged (skewed-operand pipeline).
//   - Latency: exactly STAGES cycles from input transfer to out_valid, given no stall.
//     STAGES=1 means a single registered ripple adder.
//   - Throughput: one beat per cycle while out_ready=1.
//   - Per-stage flow control: stage k loads when it is empty or stage k+1 (or output) drains this cycle.
//     Therefore bubbles collapse under stall; no beat is ever dropped or duplicated.
//   - in_ready = ~v[0] | (stage 0 advances this cycle); combinational from out_ready through the valid chain only.
//   - Full: all STAGES valid and out_ready=0 -> in_ready=0; all registers hold their values.
//   - Simultaneous in and out transfer when full: both occur and occupancy stays STAGES.
//   - sum/cout/overflow are held stable while out_valid=1 and out_ready=0.
//   - Overflow: computed in the last stage from the carry into bit WIDTH-1 and cout.
//   - Reset mid-stream: all in-flight beats are discarded. The first post-reset result is from the first post-reset input.
//   - Data registers may be ungated by valid, but outputs are only meaningful while out_valid=1.
//     Exception: after reset the outputs read 0.
// TESTING
//   1 Reset: rst=1 mid-stream with 3 beats in flight -> out_valid=0, sum=0 at once; no stale beats after release.
//   2 Add, W16/S4: a=16'hFFFF, b=16'h0001, cin=0 -> after 4 cycles: sum=16'h0000, cout=1, overflow=0.
//   3 Sub: a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, overflow=1.
//      Next: a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0.
//   4 Streaming: 100 back-to-back random beats, out_ready=1 -> results in order, one per cycle.
//     Each result equals the reference model, and the first result arrives at cycle 4.
//   5 Backpressure: out_ready=0 for 6 cycles while in_valid=1 -> in_ready falls after 4 accepts.
//     Outputs are held; on release, results arrive in order, none lost or duplicated.
//   6 Param sweep: (WIDTH,STAGES) = (8,1),(8,8),(32,4) with cin=1 corner (a=all-ones, b=0).
//     Expected: sum=0, cout=1, latency = STAGES.

Source files
------------

// File: rtl/tfa_pipelined_addsub_if.sv
// tfa_pipelined_addsub_if: operand and result valid/ready streams for the pipelined add/sub unit
//   in_valid/in_ready/a/b/cin/sub : operand beat (master drives, slave accepts)
//   out_valid/out_ready/sum/cout/overflow : result beat (slave drives, master accepts)
interface tfa_pipelined_addsub_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input in_ready, out_valid, sum, cout, overflow);
  modport slave (input in_valid, a, b, cin, sub, out_ready,
                 output in_ready, out_valid, sum, cout, overflow);
endinterface

// File: rtl/tfa_pipelined_addsub.sv
// tfa_pipelined_addsub: skewed-operand pipelined adder/subtractor built from TFA ripple slices
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of tfa_pipelined_addsub_if (operand stream in, result stream out)
module tfa_pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  tfa_pipelined_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam logic [STAGES-1:0] FULL = '1;
  logic [STAGES-1:0] v_q, v_d, ld, c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q, a_d, b_d, s_d;
  logic ov_q, ov_d, rdy_q, co, cm;
  // Stage k takes its operands from stage k-1; the modulo index keeps the
  // unselected k==0 branch in range for every STAGES value.
  always_comb begin
    co = 1'b0;
    cm = 1'b0;
    a_d = '0;
    b_d = '0;
    s_d = '0;
    c_d = '0;
    v_d = '0;
    ld = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = k == 0 ? bus.a : a_q[(k + STAGES - 1) % STAGES];
      b_d[k] = k == 0 ? (bus.sub ? ~bus.b : bus.b) : b_q[(k + STAGES - 1) % STAGES];
      s_d[k] = k == 0 ? '0 : s_q[(k + STAGES - 1) % STAGES];
      co = k == 0 ? (bus.sub | bus.cin) : c_q[(k + STAGES - 1) % STAGES];
      v_d[k] = k == 0 ? (bus.in_valid & rdy_q) : v_q[(k + STAGES - 1) % STAGES];
      // A stage can load unless it and every stage after it is full while the output stalls.
      ld[k] = bus.out_ready | ((v_q >> k) != (FULL >> k));
      for (int j = k * SW; j < (k + 1) * SW; j++) begin
        cm = co;
        s_d[k][j] = a_d[k][j] ^ b_d[k][j] ^ co;
        // TFA cell: propagate passes the carry, otherwise the carry equals a (== b).
        co = (a_d[k][j] ^ b_d[k][j]) ? co : a_d[k][j];
      end
      c_d[k] = co;
    end
    ov_d = cm ^ co;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      ov_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) v_q[k] <= v_d[k];
        if (ld[k] && v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (ld[STAGES-1] && v_d[STAGES-1]) ov_q <= ov_d;
    end
  end
  assign bus.in_ready = rdy_q & ld[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum = s_q[STAGES-1];
  assign bus.cout = c_q[STAGES-1];
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_tfa_pipelined_addsub.sv
// tb_tfa_pipelined_addsub: directed and streaming checks of the pipelined add/sub unit against a behavioural model
module tb_tfa_pipelined_addsub;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0, first_pop = -1, last_pop = -1;
  logic mark = 0, go = 0;
  logic [2:0] done = '0;
  logic [17:0] q[$];
  logic [32:0] pend[$];
  always @(posedge clk) cyc <= cyc + 1;

  tfa_pipelined_addsub_if #(.WIDTH(16)) m ();
  tfa_pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(m.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: {sum, cout, overflow}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int u, v;
    logic [15:0] r;
    u = s ? int'(a) - int'(b) : int'(a) + int'(b) + int'(c);
    v = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b)) + int'(c);
    r = u[15:0];
    return {r, s ? (a >= b) : (u > 65535), (v > 32767) || (v < -32768)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      n_push = 0;
      n_pop = 0;
    end else begin
      if (m.out_valid) begin
        if (q.size() == 0) chk("out_without_input", m.out_valid, 0);
        else begin
          chk("model_sum", m.sum, q[0][17:2]);
          chk("model_cout", m.cout, q[0][1]);
          chk("model_overflow", m.overflow, q[0][0]);
          if (m.out_ready) begin
            void'(q.pop_front());
            n_pop++;
            last_pop = cyc;
            if (mark) begin
              first_pop = cyc;
              mark = 0;
            end
          end
        end
      end
      if (m.in_valid && m.in_ready) begin
        q.push_back(model(m.a, m.b, m.cin, m.sub));
        n_push++;
      end
    end
  end

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s, output logic took);
    m.in_valid = 1;
    m.a = a;
    m.b = b;
    m.cin = c;
    m.sub = s;
    @(negedge clk);
    took = m.in_ready;
    @(posedge clk);
    #1 m.in_valid = 0;
  endtask

  task automatic lit(input string nm, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                     input logic [15:0] es, input logic ec, input logic eo);
    logic took;
    int lat;
    beat(a, b, c, s, took);
    chk({nm, "_accept"}, took, 1);
    lat = 1;
    while (!m.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_sum"}, m.sum, es);
    chk({nm, "_cout"}, m.cout, ec);
    chk({nm, "_overflow"}, m.overflow, eo);
    @(posedge clk);
    #1;
  endtask

  localparam int SWW[3] = '{8, 8, 32};
  localparam int SWS[3] = '{1, 8, 4};
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = SWW[g];
    localparam int S = SWS[g];
    tfa_pipelined_addsub_if #(.WIDTH(W)) sif ();
    tfa_pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst), .bus(sif.slave));
    initial begin
      int lat;
      sif.in_valid = 0;
      sif.a = '1;
      sif.b = '0;
      sif.cin = 1;
      sif.sub = 0;
      sif.out_ready = 1;
      wait (go);
      @(posedge clk);
      #1 sif.in_valid = 1;
      @(negedge clk);
      chk($sformatf("sweep_w%0d_s%0d_accept", W, S), sif.in_ready, 1);
      @(posedge clk);
      #1 sif.in_valid = 0;
      lat = 1;
      while (!sif.out_valid && lat < 40) begin
        @(posedge clk);
        #1 lat++;
      end
      chk($sformatf("sweep_w%0d_s%0d_latency", W, S), lat, S);
      chk($sformatf("sweep_w%0d_s%0d_sum", W, S), sif.sum, 0);
      chk($sformatf("sweep_w%0d_s%0d_cout", W, S), sif.cout, 1);
      chk($sformatf("sweep_w%0d_s%0d_overflow", W, S), sif.overflow, 0);
      done[g] = 1;
    end
  end

  initial begin
    logic took;
    int acc, cnt, start;
    logic [32:0] p;
    m.in_valid = 0;
    m.a = 0;
    m.b = 0;
    m.cin = 0;
    m.sub = 0;
    m.out_ready = 1;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", m.out_valid, 0);
    chk("reset_sum", m.sum, 0);
    chk("reset_cout", m.cout, 0);
    chk("reset_overflow", m.overflow, 0);
    rst = 0;
    @(posedge clk);
    #1 chk("in_ready_after_reset", m.in_ready, 1);
    lit("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    lit("sub_overflow", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    lit("sub_borrow", 16'h0003, 16'h0005, 0, 1, 16'hFFFE, 0, 0);
    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) beat(16'(i + 10), 16'h0100, 0, 0, took);
    rst = 1;
    #1;
    chk("midreset_out_valid", m.out_valid, 0);
    chk("midreset_sum", m.sum, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1 cnt += int'(m.out_valid);
    end
    chk("no_stale_after_reset", cnt, 0);
    lit("post_reset_first", 16'h0001, 16'h0002, 1, 0, 16'h0004, 0, 0);
    go = 1;
    // Back-to-back random stream
    acc = 0;
    mark = 1;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), took);
      acc += int'(took);
    end
    cnt = 0;
    while (q.size() != 0 && cnt < 50) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("stream_accepts", acc, 100);
    chk("stream_drained", q.size(), 0);
    chk("stream_first_latency", first_pop - start, 4);
    chk("stream_one_per_cycle", last_pop - first_pop, 99);
    // Backpressure: output stalled while operands keep arriving
    m.out_ready = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      p = {16'(i * 1111 + 7), 16'(i * 333), 1'(i % 2)};
      beat(p[32:17], p[16:1], 0, p[0], took);
      if (took) acc++;
      else pend.push_back(p);
    end
    chk("bp_accepts", acc, 4);
    chk("bp_in_ready_low", m.in_ready, 0);
    chk("bp_out_valid_held", m.out_valid, 1);
    m.out_ready = 1;
    while (pend.size() != 0) begin
      p = pend.pop_front();
      cnt = 0;
      took = 0;
      while (!took && cnt < 10) begin
        beat(p[32:17], p[16:1], 0, p[0], took);
        cnt++;
      end
      chk("bp_retry_accepted", took, 1);
    end
    beat(16'h1234, 16'h4321, 1, 0, took);
    beat(16'h0000, 16'h0001, 0, 1, took);
    cnt = 0;
    while (q.size() != 0 && cnt < 50) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_in_equals_out", n_pop, n_push);
    cnt = 0;
    while (done != 3'b111 && cnt < 200) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("sweep_done", done, 3'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
